// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous data-memory port between the LSU (port 0)
// and the image loader/DMA (port 1), with starvation relief, atomic lock sequences and read-data routing.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state_dbg,
  output logic [3:0]        starve_cnt_dbg
);

  // Handshake: an access is accepted on a rising edge where valid & ready; ready is
  // combinational and never depends on the request's own lock/we/addr fields.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state, state_next;
  logic [3:0]        starve_cnt, starve_next;
  logic              grant0, grant1;
  logic              pend_valid, pend_port;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            if (starve_cnt >= LIMIT) grant1 = 1'b1;
            else                     grant0 = 1'b1;
          end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
          end
        end
        LOCK0:   grant0 = req0_valid;
        LOCK1:   grant1 = req1_valid;
        default: ;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // A grant with lock set takes (or keeps) ownership; a grant without lock releases it.
  always_comb begin
    state_next = state;
    if (grant0)      state_next = req0_lock ? LOCK0 : IDLE;
    else if (grant1) state_next = req1_lock ? LOCK1 : IDLE;
  end

  // The count is frozen while port 0 owns the memory, so the lock does not itself earn port 1 a slot.
  always_comb begin
    starve_next = starve_cnt;
    if (state == LOCK0)              starve_next = starve_cnt;
    else if (!req1_valid || grant1)  starve_next = 4'd0;
    else if (starve_cnt < LIMIT)     starve_next = starve_cnt + 4'd1;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant0) begin
      mem_we    = req0_we;
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
    end else if (grant1) begin
      mem_we    = req1_we;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      pend_valid <= 1'b0;
      pend_port  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      pend_valid <= (grant0 && !req0_we) || (grant1 && !req1_we);
      pend_port  <= grant1;
      if (req0_rvalid) rdata0_q <= mem_rdata;
      if (req1_rvalid) rdata1_q <= mem_rdata;
    end
  end

  // Memory data arrives during the cycle after the grant; it is steered straight to the
  // tagged port and then held. A reset in that cycle drops the delivery.
  assign req0_rvalid = pend_valid && !pend_port && !rst;
  assign req1_rvalid = pend_valid &&  pend_port && !rst;
  assign req0_rdata  = req0_rvalid ? mem_rdata : rdata0_q;
  assign req1_rdata  = req1_rvalid ? mem_rdata : rdata1_q;

  assign state_dbg      = state;
  assign starve_cnt_dbg = starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked against an
// ownership/wait-count reference model and a behavioural synchronous memory.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk, rst;
  logic        req0_valid, req0_we, req0_lock, req0_ready, req0_rvalid;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_we, req1_lock, req1_ready, req1_rvalid;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  state_dbg;
  logic [3:0]  starve_cnt_dbg;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state_dbg(state_dbg), .starve_cnt_dbg(starve_cnt_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Behavioural synchronous memory driven by the DUT's memory port
  logic [31:0] env_mem [logic [31:0]];
  always @(posedge clk) begin
    mem_rdata <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_val(mem_addr);
    if (mem_we) env_mem[mem_addr] = mem_wdata;
  end

  // Reference model: who owns the port, how long port 1 has waited, what read is in flight
  logic [31:0] ref_mem [logic [31:0]];
  int          owner;      // 0 nobody, 1 port 0, 2 port 1
  int          wait_c;
  bit          pend_v, pend_p, known;
  logic [31:0] pend_d, last0, last1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one cycle of stimulus, prediction and comparison
  task automatic step(input bit v0, input bit we0, input bit lk0, input logic [31:0] a0,
                      input logic [31:0] d0, input bit v1, input bit we1, input bit lk1,
                      input logic [31:0] a1, input logic [31:0] d1, input bit r);
    bit g0, g1, ev0, ev1, gwe, glk;
    logic [31:0] ga, gd;
    @(negedge clk);
    rst = r;
    req0_valid = v0; req0_we = we0; req0_lock = lk0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_lock = lk1; req1_addr = a1; req1_wdata = d1;
    #1;
    g0 = 0; g1 = 0;
    if (!r) begin
      if (owner == 1)       g0 = v0;
      else if (owner == 2)  g1 = v1;
      else if (v0 && v1) begin
        if (wait_c >= LIMIT) g1 = 1; else g0 = 1;
      end else begin
        g0 = v0; g1 = v1;
      end
    end
    gwe = g0 ? we0 : (g1 ? we1 : 1'b0);
    glk = g0 ? lk0 : lk1;
    ga  = g0 ? a0  : (g1 ? a1 : 32'h0);
    gd  = g0 ? d0  : (g1 ? d1 : 32'h0);
    ev0 = pend_v && !pend_p && !r;
    ev1 = pend_v &&  pend_p && !r;

    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));
    check("mem_we", 32'(mem_we), 32'(gwe));
    check("mem_addr", mem_addr, ga);
    check("mem_wdata", mem_wdata, gd);
    check("req0_rvalid", 32'(req0_rvalid), 32'(ev0));
    check("req1_rvalid", 32'(req1_rvalid), 32'(ev1));
    if (known) begin
      check("req0_rdata", req0_rdata, ev0 ? pend_d : last0);
      check("req1_rdata", req1_rdata, ev1 ? pend_d : last1);
      check("state", 32'(state_dbg), 32'(owner));
      check("starve_cnt", 32'(starve_cnt_dbg), 32'(wait_c));
    end

    // Model update for the coming edge
    if (r) begin
      owner = 0; wait_c = 0; pend_v = 0; last0 = 0; last1 = 0; known = 1;
    end else begin
      if (ev0) last0 = pend_d;
      if (ev1) last1 = pend_d;
      if (owner != 1) begin
        if (!v1 || g1)          wait_c = 0;
        else if (wait_c < LIMIT) wait_c++;
      end
      pend_v = (g0 || g1) && !gwe;
      pend_p = g1;
      if (pend_v) pend_d = ref_mem.exists(ga) ? ref_mem[ga] : init_val(ga);
      if ((g0 || g1) && gwe) ref_mem[ga] = gd;
      if (g0 || g1) owner = glk ? (g0 ? 1 : 2) : 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0,0,0,0,0, 0,0,0,0,0, 0);
  endtask

  initial begin
    owner = 0; wait_c = 0; pend_v = 0; pend_p = 0; pend_d = 0;
    last0 = 0; last1 = 0; known = 0;
    mem_rdata = 0;
    env_mem[32'h404] = 32'h999;
    ref_mem[32'h404] = 32'h999;

    // Reset with both ports requesting, then port 0 wins first
    step(1,0,0,32'h10,0, 1,0,0,32'h20,0, 1);
    step(1,0,0,32'h10,0, 1,0,0,32'h20,0, 1);
    step(1,0,0,32'h10,0, 1,0,0,32'h20,0, 0);
    idle(2);

    // Single read returning 0x999 to port 0
    step(1,0,0,32'h404,0, 0,0,0,0,0, 0);
    idle(2);

    // Continuous contention: 4 grants to port 0, then port 1, then port 0
    for (int i = 0; i < 7; i++) step(1,0,0,32'h8,0, 1,0,0,32'hC,0, 0);
    idle(2);

    // Locked read-modify-write by port 1 while port 0 keeps asking
    step(0,0,0,0,0, 1,0,1,32'h400,0, 0);
    step(1,0,0,32'h404,0, 1,1,0,32'h400,32'hF, 0);
    step(1,0,0,32'h404,0, 0,0,0,0,0, 0);
    step(1,0,0,32'h400,0, 0,0,0,0,0, 0);
    idle(2);

    // Back-to-back reads to both ports
    step(1,0,0,32'h4100,0, 0,0,0,0,0, 0);
    step(0,0,0,0,0, 1,0,0,32'h30000,0, 0);
    idle(2);

    // Reset while port 0 holds the lock with a read in flight
    step(1,0,1,32'h404,0, 0,0,0,0,0, 0);
    step(1,0,0,32'h404,0, 1,0,0,32'h20,0, 1);
    step(0,0,0,0,0, 1,0,0,32'h20,0, 0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,3) == 0,
           32'($urandom_range(0,7)) << 2, $urandom,
           $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,3) == 0,
           32'($urandom_range(0,7)) << 2, $urandom,
           $urandom_range(0,49) == 0);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
